core_fetch_buffer: RTL and testbench

CORE_FETCH_BUFFER -- requirements
Module: core_fetch_buffer

---
 rtl/core_pkg.sv | 15 +
 rtl/core_sync_fifo.sv | 60 ++++++
 rtl/core_fetch_buffer.sv | 99 +++++++++
 tb/tb_core_fetch_buffer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: canonical NOP and the fetch-buffer entry layout.
package core_pkg;

  // addi x0, x0, 0 -- what an empty buffer slot decodes as
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          CORE_XLEN = 32;

  // One buffered fetch at the default core width. Modules built with a
  // different XLEN declare the same {pc, instr} layout at their own width.
  typedef struct packed {
    logic [CORE_XLEN-1:0] pc;
    logic [31:0]          instr;
  } fetch_entry_t;

endpackage

// File: rtl/core_sync_fifo.sv
// Small synchronous FIFO: head word is read straight out of storage,
// reset initialises every slot, clear only empties the queue.
module core_sync_fifo #(
  parameter int               WIDTH   = 64,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CW      = $clog2(DEPTH+1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [CW-1:0]    o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             wr, rd;

  // clear wins over both ports; a read of an empty queue is ignored
  assign wr = i_wr_en & ~i_clr;
  assign rd = i_rd_en & ~i_clr & (count != '0);

  // Storage: reset loads the fill pattern, otherwise write at tail
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
    end else if (wr) begin
      mem[wr_ptr] <= i_wr_data;
    end
  end

  // Pointers and occupancy; power-of-two depth makes pointer wrap free
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      if (wr && !rd)      count <= count + CW'(1);
      else if (!wr && rd) count <= count - CW'(1);
    end
  end

  assign o_rd_data = mem[rd_ptr];
  assign o_count   = count;

  // upstream flow control must never let a write land on a full queue
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(wr && !rd && count == CW'(DEPTH)));

endmodule

// File: rtl/core_fetch_buffer.sv
// Fetch buffer between the PC/imem stage and decode. Tracks the single
// in-flight imem request, pairs its PC with the returning word, and queues
// the pair for decode. Flush drops everything except a same-cycle fetch.
module core_fetch_buffer
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic                         i_fetch_valid,
  input  logic [XLEN-1:0]              i_fetch_pc,
  output logic                         o_fetch_ready,
  input  logic                         i_imem_rvalid,
  input  logic [31:0]                  i_imem_rdata,
  output logic                         o_id_valid,
  output logic [XLEN-1:0]              o_id_pc,
  output logic [31:0]                  o_id_instr,
  input  logic                         i_id_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_err_unexp
);

  localparam int CW = $clog2(DEPTH+1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("core_fetch_buffer: DEPTH must be a power of two >= 2");
  end

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  localparam int EW = $bits(entry_t);

  logic            pend_q, err_q;
  logic [XLEN-1:0] pend_pc_q;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic            fetch_acc, enq, deq, unexp;
  entry_t          wr_ent, head;

  // Ready counts the in-flight slot as already used so a response always
  // has room; it deliberately ignores this cycle's dequeue.
  assign occ           = {1'b0, count} + {{CW{1'b0}}, pend_q};
  assign o_fetch_ready = i_flush | (occ < (CW+1)'(DEPTH));
  assign fetch_acc     = i_fetch_valid & o_fetch_ready;

  assign enq   = i_imem_rvalid & pend_q & ~i_flush;
  assign unexp = i_imem_rvalid & ~pend_q & ~i_flush;

  assign o_id_valid = (count != '0) & ~i_flush;
  assign deq        = o_id_valid & i_id_ready;

  assign wr_ent.pc    = pend_pc_q;
  assign wr_ent.instr = i_imem_rdata;

  // In-flight request: set on accept, retired by its response, killed by flush
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      pend_q <= fetch_acc | (pend_q & ~enq & ~i_flush);
      if (fetch_acc) pend_pc_q <= i_fetch_pc;
    end
  end

  // Sticky protocol error: response arrived with nothing outstanding
  always_ff @(posedge i_clk) begin
    if (i_rst)      err_q <= 1'b0;
    else if (unexp) err_q <= 1'b1;
  end

  core_sync_fifo #(
    .WIDTH   (EW),
    .DEPTH   (DEPTH),
    .RST_VAL ({{XLEN{1'b0}}, NOP_INSTR}),
    .CW      (CW)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (i_flush),
    .i_wr_en   (enq),
    .i_wr_data (wr_ent),
    .i_rd_en   (deq),
    .o_rd_data (head),
    .o_count   (count)
  );

  assign o_id_pc     = head.pc;
  assign o_id_instr  = head.instr;
  assign o_count     = count;
  assign o_err_unexp = err_q;

endmodule

// File: tb/tb_core_fetch_buffer.sv
// Directed bench for core_fetch_buffer (XLEN 32, DEPTH 2). Each table row is
// one clock: inputs are driven just after the rising edge and outputs are
// sampled 1ns later, before the next edge.
module tb_core_fetch_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH+1);

  localparam logic [31:0] A   = 32'h4000_0000, B  = 32'h4000_0004;
  localparam logic [31:0] C   = 32'h4000_0008, D  = 32'h4000_0100;
  localparam logic [31:0] E   = 32'h4000_0300;
  localparam logic [31:0] IA  = 32'h0000_0093, IB = 32'h0000_0113;
  localparam logic [31:0] IC  = 32'h0000_0193, ID = 32'h0000_0213;
  localparam logic [31:0] IE  = 32'h0000_0293;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst, flush, fetch_valid, fetch_ready, imem_rvalid;
  logic            id_valid, id_ready, err_unexp;
  logic [XLEN-1:0] fetch_pc, id_pc;
  logic [31:0]     imem_rdata, id_instr;
  logic [CW-1:0]   count;

  always #5 clk = ~clk;

  core_fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_flush       (flush),
    .i_fetch_valid (fetch_valid),
    .i_fetch_pc    (fetch_pc),
    .o_fetch_ready (fetch_ready),
    .i_imem_rvalid (imem_rvalid),
    .i_imem_rdata  (imem_rdata),
    .o_id_valid    (id_valid),
    .o_id_pc       (id_pc),
    .o_id_instr    (id_instr),
    .i_id_ready    (id_ready),
    .o_count       (count),
    .o_err_unexp   (err_unexp)
  );

  typedef struct {
    logic        rst, flush, fv;
    logic [31:0] pc;
    logic        rv;
    logic [31:0] rdata;
    logic        idr;
    logic        e_rdy, e_vld;
    logic [31:0] e_pc, e_instr;
    int          e_cnt;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t v(input logic r, f, fv, input logic [31:0] pc,
                             input logic rv, input logic [31:0] rd, input logic idr,
                             input logic er, ev, input logic [31:0] ep, ei,
                             input int ec, input logic ee);
    vec_t t;
    t.rst = r; t.flush = f; t.fv = fv; t.pc = pc; t.rv = rv; t.rdata = rd;
    t.idr = idr; t.e_rdy = er; t.e_vld = ev; t.e_pc = ep; t.e_instr = ei;
    t.e_cnt = ec; t.e_err = ee;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, f, fv, input logic [31:0] pc,
                       input logic rv, input logic [31:0] rd, input logic idr);
    rst = r; flush = f; fetch_valid = fv; fetch_pc = pc;
    imem_rvalid = rv; imem_rdata = rd; id_ready = idr;
  endtask

  task automatic chk_outs(input string tag, input logic er, ev,
                          input logic [31:0] ep, ei, input int ec, input logic ee);
    chk({tag, " ready"}, 32'(fetch_ready), 32'(er));
    chk({tag, " valid"}, 32'(id_valid),    32'(ev));
    chk({tag, " pc"},    id_pc,            ep);
    chk({tag, " instr"}, id_instr,         ei);
    chk({tag, " count"}, 32'(count),       32'(ec));
    chk({tag, " err"},   32'(err_unexp),   32'(ee));
  endtask

  initial begin
    int lat;
    logic [31:0] lat_pc, lat_instr;

    // rst flush fv pc  rv rdata idr | rdy vld pc instr cnt err
    // single fetch through to decode
    tbl.push_back(v(0,0,1,A, 0,0, 1,  1,0,0,NOP,0,0));
    tbl.push_back(v(0,0,0,0, 1,IA,1,  1,0,0,NOP,0,0));
    tbl.push_back(v(0,0,0,0, 0,0, 1,  1,1,A,IA, 1,0));
    tbl.push_back(v(0,0,0,0, 0,0, 1,  1,0,0,NOP,0,0));
    // decode stalled: third back-to-back fetch is refused, then drain in order
    tbl.push_back(v(0,0,1,A, 0,0, 0,  1,0,0,NOP,0,0));
    tbl.push_back(v(0,0,1,B, 1,IA,0,  1,0,0,NOP,0,0));
    tbl.push_back(v(0,0,1,C, 1,IB,0,  0,1,A,IA, 1,0));
    tbl.push_back(v(0,0,1,C, 0,0, 0,  0,1,A,IA, 2,0));
    tbl.push_back(v(0,0,0,0, 0,0, 1,  0,1,A,IA, 2,0));
    tbl.push_back(v(0,0,0,0, 0,0, 1,  1,1,B,IB, 1,0));
    tbl.push_back(v(0,0,0,0, 0,0, 0,  1,0,A,IA, 0,0));
    // fill both entries, then flush with a new fetch and a stale response
    tbl.push_back(v(0,0,1,C, 0,0, 0,  1,0,A,IA, 0,0));
    tbl.push_back(v(0,0,1,B, 1,IC,0,  1,0,A,IA, 0,0));
    tbl.push_back(v(0,0,0,0, 1,IB,0,  0,1,C,IC, 1,0));
    tbl.push_back(v(0,1,1,D, 1,IA,1,  1,0,C,IC, 2,0));
    tbl.push_back(v(0,0,0,0, 1,ID,0,  1,0,B,IB, 0,0));
    tbl.push_back(v(0,0,0,0, 0,0, 1,  1,1,D,ID, 1,0));
    tbl.push_back(v(0,0,0,0, 0,0, 1,  1,0,C,IC, 0,0));
    // held fetch stream with decode always ready: ready cannot see this
    // cycle's dequeue, so one slot in three is refused; count stays <= 1
    tbl.push_back(v(0,0,1,A, 0,0, 1,  1,0,C,IC, 0,0));
    tbl.push_back(v(0,0,1,B, 1,IA,1,  1,0,C,IC, 0,0));
    tbl.push_back(v(0,0,1,C, 1,IB,1,  0,1,A,IA, 1,0));
    tbl.push_back(v(0,0,1,C, 0,0, 1,  1,1,B,IB, 1,0));
    tbl.push_back(v(0,0,1,D, 1,IC,1,  1,0,A,IA, 0,0));
    tbl.push_back(v(0,0,0,0, 1,ID,1,  0,1,C,IC, 1,0));
    tbl.push_back(v(0,0,0,0, 0,0, 1,  1,1,D,ID, 1,0));
    tbl.push_back(v(0,0,0,0, 0,0, 1,  1,0,C,IC, 0,0));
    // unexpected response: sticky error, count untouched
    tbl.push_back(v(0,0,0,0, 1,IA,1,  1,0,C,IC, 0,0));
    tbl.push_back(v(0,0,0,0, 0,0, 1,  1,0,C,IC, 0,1));
    tbl.push_back(v(0,0,1,A, 0,0, 1,  1,0,C,IC, 0,1));
    tbl.push_back(v(0,0,0,0, 1,IA,0,  1,0,C,IC, 0,1));
    tbl.push_back(v(0,0,0,0, 0,0, 0,  1,1,A,IA, 1,1));
    // reset with an entry queued and a response in flight; the response
    // arriving after release counts as unexpected
    tbl.push_back(v(0,0,1,B, 0,0, 0,  1,1,A,IA, 1,1));
    tbl.push_back(v(1,0,1,C, 1,IB,0,  0,1,A,IA, 1,1));
    tbl.push_back(v(0,0,0,0, 1,IC,0,  1,0,0,NOP,0,0));
    tbl.push_back(v(0,0,0,0, 0,0, 0,  1,0,0,NOP,0,1));

    // power-on reset
    drive(1,0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    #1 drive(0,0,0,0,0,0,0);
    #1 chk_outs("reset", 1,0,0,NOP,0,0);

    foreach (tbl[i]) begin
      @(posedge clk);
      #1 drive(tbl[i].rst, tbl[i].flush, tbl[i].fv, tbl[i].pc,
               tbl[i].rv, tbl[i].rdata, tbl[i].idr);
      #1 chk_outs($sformatf("v%0d", i), tbl[i].e_rdy, tbl[i].e_vld,
                  tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_cnt, tbl[i].e_err);
    end

    // accept-to-valid latency, bounded wait
    lat = -1; lat_pc = '0; lat_instr = '0;
    @(posedge clk);
    #1 drive(0,0,1,E,0,0,0);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1 drive(0,0,0,0,(c == 1),IE,0);
      #1 if (id_valid && lat < 0) begin
        lat = c; lat_pc = id_pc; lat_instr = id_instr;
      end
    end
    chk("latency", 32'(lat), 32'd2);
    chk("latency pc", lat_pc, E);
    chk("latency instr", lat_instr, IE);

    // two entries queued, then reset wins over flush/fetch/response/dequeue
    @(posedge clk);
    #1 drive(0,0,1,B,0,0,0);
    @(posedge clk);
    #1 drive(0,0,1,C,1,IB,0);
    @(posedge clk);
    #1 drive(1,1,1,D,1,IC,1);
    #1 chk("full count", 32'(count), 32'd2);
    chk("full ready", 32'(fetch_ready), 32'd1);
    @(posedge clk);
    #1 drive(0,0,0,0,0,0,0);
    #1 chk_outs("rst_full", 1,0,0,NOP,0,0);
    @(posedge clk);
    #2 chk_outs("rst_idle", 1,0,0,NOP,0,0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
